gray_code_counter: RTL and testbench

GRAY_CODE_COUNTER -- requirements
Module: gray_code_counter

---
 rtl/gray_pkg.sv | 12 +
 rtl/binary_to_gray.sv | 15 +
 rtl/gray_code_counter.sv | 77 +++++++
 tb/tb_gray_code_counter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared constants and the binary-to-Gray encode function for the Gray code counter.
package gray_pkg;

    localparam int unsigned GRAY_W_DEF = 4;
    localparam int unsigned GRAY_W_MAX = 16;

    // Operates at the maximum width; narrower callers zero-extend and truncate.
    function automatic logic [GRAY_W_MAX-1:0] encode(input logic [GRAY_W_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Purely combinational binary-to-Gray converter built on the shared encode function.
module binary_to_gray
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_W_DEF
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    always_comb begin
        gray = WIDTH'(encode(GRAY_W_MAX'(bin)));
    end

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with loadable value, registered Gray output and wrap pulse.
module gray_code_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             wrap
);

    logic [1:0]       rst_sync_q;
    logic             run;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    // Assertion is immediate; release only takes effect after two clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (run) begin
            if (load) begin
                bin_d = load_bin;
            end else if (en) begin
                if (up) begin
                    bin_d  = bin_q + WIDTH'(1);
                    wrap_d = &bin_q;
                end else begin
                    bin_d  = bin_q - WIDTH'(1);
                    wrap_d = ~|bin_q;
                end
            end
        end
    end

    // Encoding the next value keeps gray and bin aligned in the same cycle.
    binary_to_gray #(
        .WIDTH(WIDTH)
    ) u_enc (
        .bin  (bin_d),
        .gray (gray_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Self-checking bench: arithmetic reference model plus directed literal vectors.
module tb_gray_code_counter;
    import gray_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_bin;
    logic [3:0] gray;
    logic [3:0] bin;
    logic       wrap;

    int total = 0;
    int bad   = 0;

    bit model_run = 0;
    bit cmp_on    = 0;
    bit prop_on   = 0;

    int         m_val  = 0;
    bit         m_wrap = 0;
    logic [3:0] prev_gray = '0;

    logic [3:0] seq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                             4'b0110, 4'b0111, 4'b0101, 4'b0100,
                             4'b1100, 4'b1101, 4'b1111, 4'b1110,
                             4'b1010, 4'b1011, 4'b1001, 4'b1000};

    gray_code_counter #(
        .WIDTH(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .gray     (gray),
        .bin      (bin),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit e, input bit u, input bit l, input logic [3:0] lb);
        en       = e;
        up       = u;
        load     = l;
        load_bin = lb;
        @(posedge clk);
        #1;
    endtask

    // Reference model: count modulo 16 with plain integer arithmetic.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val  = 0;
            m_wrap = 0;
        end else if (model_run) begin
            if (load) begin
                m_val  = int'(load_bin);
                m_wrap = 0;
            end else if (en && up) begin
                m_wrap = (m_val == 15);
                m_val  = (m_val + 1) % 16;
            end else if (en) begin
                m_wrap = (m_val == 0);
                m_val  = (m_val + 15) % 16;
            end else begin
                m_wrap = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_bin", 32'(bin), 32'(m_val));
            check("model_gray", 32'(gray), 32'(encode(16'(m_val))));
            check("model_wrap", 32'(wrap), 32'(m_wrap));
            check("gray_enc", 32'(gray), 32'(encode(16'(bin))));
        end
        if (prop_on && (gray !== prev_gray)) begin
            check("one_bit", 32'($countones(gray ^ prev_gray)), 32'd1);
        end
        prev_gray = gray;
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        up       = 1'b1;
        load     = 1'b0;
        load_bin = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_bin", 32'(bin), 32'd0);
        check("reset_gray", 32'(gray), 32'd0);
        check("reset_wrap", 32'(wrap), 32'd0);

        // Release with en held high: the first edge afterwards must not count.
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("no_count_first_edge", 32'(bin), 32'd0);

        rst_n = 1'b0;
        en    = 1'b0;
        #3 rst_n = 1'b1;
        repeat (3) step(0, 0, 0, 4'd0);
        model_run = 1;
        cmp_on    = 1;

        check("up_start", 32'(gray), 32'(seq[0]));
        for (int k = 1; k <= 16; k++) begin
            step(1, 1, 0, 4'd0);
            check("up_gray", 32'(gray), 32'(seq[k % 16]));
            check("up_wrap", 32'(wrap), (k == 16) ? 32'd1 : 32'd0);
        end
        step(0, 1, 0, 4'd0);
        check("wrap_one_cycle", 32'(wrap), 32'd0);

        step(1, 0, 0, 4'd0);
        check("down_bin", 32'(bin), 32'hF);
        check("down_gray", 32'(gray), 32'h8);
        check("down_wrap", 32'(wrap), 32'd1);
        step(1, 0, 0, 4'd0);
        check("down2_bin", 32'(bin), 32'hE);
        check("down2_gray", 32'(gray), 32'h9);
        check("down2_wrap", 32'(wrap), 32'd0);

        step(1, 1, 1, 4'b1010);
        check("load_bin", 32'(bin), 32'hA);
        check("load_gray", 32'(gray), 32'hF);
        check("load_wrap", 32'(wrap), 32'd0);

        step(0, 0, 1, 4'hF);
        step(1, 1, 1, 4'h3);
        check("load_at_max_bin", 32'(bin), 32'h3);
        check("load_at_max_wrap", 32'(wrap), 32'd0);

        step(0, 0, 1, 4'b0101);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 4'd0);
            check("hold_gray", 32'(gray), 32'h7);
            check("hold_bin", 32'(bin), 32'h5);
        end
        for (int i = 0; i < 6; i++) begin
            step(1, (i % 2) == 0, 0, 4'd0);
            check("toggle_bin", 32'(bin), ((i % 2) == 0) ? 32'h6 : 32'h5);
        end

        step(0, 0, 1, 4'd2);
        step(1, 1, 0, 4'd0);
        step(1, 1, 0, 4'd0);
        check("pre_reset_gray", 32'(gray), 32'h6);
        #2 rst_n = 1'b0;
        #1;
        check("async_bin", 32'(bin), 32'd0);
        check("async_gray", 32'(gray), 32'd0);
        check("async_wrap", 32'(wrap), 32'd0);
        load     = 1'b1;
        load_bin = 4'h9;
        en       = 1'b1;
        @(posedge clk);
        #1;
        check("reset_overrides_bin", 32'(bin), 32'd0);
        check("reset_overrides_gray", 32'(gray), 32'd0);
        load  = 1'b0;
        en    = 1'b0;
        rst_n = 1'b1;
        repeat (3) step(0, 0, 0, 4'd0);

        prop_on = 1;
        repeat (1000) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 4'd0);
        prop_on = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
